// File: rtl/iguana_boot_pkg.sv
// Shared types and constants for the Iguana boot sequencer.
package iguana_boot_pkg;

  typedef enum logic [2:0] {
    PWRUP   = 3'd0,
    DECIDE  = 3'd1,
    PRELOAD = 3'd2,
    AUTO    = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5,
    FIN     = 3'd6
  } boot_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BOOT    = 2'd1,
    ERR_PREL    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } boot_err_e;

  // Boot-mode strap encodings
  localparam logic [1:0] BOOT_IDLE  = 2'd0;
  localparam logic [1:0] BOOT_SD    = 2'd1;
  localparam logic [1:0] BOOT_AUTO0 = 2'd2;
  localparam logic [1:0] BOOT_AUTO1 = 2'd3;

  // Preload-mode strap encodings
  localparam logic [1:0] PREL_JTAG  = 2'd0;
  localparam logic [1:0] PREL_SLINK = 2'd1;
  localparam logic [1:0] PREL_UART  = 2'd2;
  localparam logic [1:0] PREL_RSVD  = 2'd3;

  // One-hot grant {uart, slink, jtag} for a supported preload mode
  function automatic logic [2:0] prel_onehot(input logic [1:0] mode);
    logic [2:0] gnt;
    gnt = 3'b000;
    if (mode != PREL_RSVD) gnt = 3'b001 << mode;
    return gnt;
  endfunction

endpackage

// File: rtl/iguana_boot_itv_cnt.sv
// Saturating cycle counter that also reports how many equal intervals of the
// full count have elapsed. The final interval completes exactly at MaxCnt,
// absorbing any remainder of the integer division.
module iguana_boot_itv_cnt #(
  parameter int unsigned MaxCnt  = 60000,
  parameter int unsigned NumItvs = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [3:0] itv_o,
  output logic       done_o,
  output logic       last_o
);

  localparam int unsigned CW     = $clog2(MaxCnt + 1);
  localparam int unsigned ItvLen = MaxCnt / NumItvs;
  localparam logic [CW-1:0] CntMax  = CW'(MaxCnt);
  localparam logic [CW-1:0] CntItv  = CW'(ItvLen);
  localparam logic [3:0]    ItvAll  = 4'(NumItvs);
  localparam logic [3:0]    ItvLast = 4'(NumItvs - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] mark_q, mark_d;
  logic [3:0]    itv_q, itv_d;
  logic          done_q, done_d;
  logic          last_d;

  // Next-state: count while enabled, tick the interval index at each mark
  always_comb begin
    cnt_d  = cnt_q;
    mark_d = mark_q;
    itv_d  = itv_q;
    done_d = done_q;
    last_d = 1'b0;
    if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CntMax) begin
        itv_d  = ItvAll;
        done_d = 1'b1;
        last_d = 1'b1;
      end else if ((itv_q < ItvLast) && (cnt_d == mark_q)) begin
        itv_d  = itv_q + 1'b1;
        mark_d = mark_q + CntItv;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      mark_q <= CntItv;
      itv_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mark_q <= mark_d;
      itv_q  <= itv_d;
      done_q <= done_d;
    end
  end

  assign itv_o  = itv_q;
  assign done_o = done_q;
  assign last_o = last_d;

endmodule

// File: rtl/iguana_boot_seq.sv
// Iguana SoC boot sequencer: HyperRAM power-up wait, strap decode, preload
// grant or autonomous start, EOC exit-code capture and timeout detection.
module iguana_boot_seq
  import iguana_boot_pkg::*;
#(
  parameter int unsigned PowerupCycles = 60000,
  parameter int unsigned NumItvs       = 5,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  output logic        hyp_pwr_done_o,
  output logic [3:0]  progress_o,
  output logic [2:0]  preload_gnt_o,
  input  logic [2:0]  preload_done_i,
  output logic        boot_start_o,
  input  logic        eoc_we_i,
  input  logic [31:0] eoc_wdata_i,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic [1:0]  error_o
);

  // A zero timeout still needs a legal one-bit counter
  localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TW-1:0] TMax = TW'(TimeoutCycles);

  boot_state_e   state_q;
  logic [1:0]    boot_q, prel_q;
  logic [2:0]    gnt_q;
  logic          boot_start_q;
  logic          done_q;
  logic [31:0]   exit_q;
  boot_err_e     err_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout;
  logic          eoc_vld;
  logic          gnt_hit;
  logic          pwr_last;

  iguana_boot_itv_cnt #(
    .MaxCnt  (PowerupCycles),
    .NumItvs (NumItvs)
  ) u_pwr_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == PWRUP),
    .itv_o  (progress_o),
    .done_o (hyp_pwr_done_o),
    .last_o (pwr_last)
  );

  // Timeout counter runs from DECIDE through RUN and saturates at its limit
  always_comb begin
    tcnt_d = tcnt_q;
    if (((state_q == DECIDE) || (state_q == PRELOAD) ||
         (state_q == AUTO)   || (state_q == RUN)) && (tcnt_q != TMax))
      tcnt_d = tcnt_q + 1'b1;
  end

  assign tout    = (TimeoutCycles != 0) && (tcnt_d == TMax);
  assign eoc_vld = eoc_we_i && eoc_wdata_i[0];
  assign gnt_hit = |(preload_done_i & gnt_q);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PWRUP;
      boot_q       <= '0;
      prel_q       <= '0;
      gnt_q        <= '0;
      boot_start_q <= 1'b0;
      done_q       <= 1'b0;
      exit_q       <= '0;
      err_q        <= ERR_NONE;
      tcnt_q       <= '0;
    end else begin
      tcnt_q       <= tcnt_d;
      boot_start_q <= 1'b0;
      case (state_q)
        PWRUP: begin
          if (pwr_last) begin
            boot_q  <= boot_mode_i;
            prel_q  <= preload_mode_i;
            state_q <= DECIDE;
          end
        end
        DECIDE: begin
          if (boot_q == BOOT_IDLE) begin
            if (prel_q == PREL_RSVD) begin
              err_q   <= ERR_PREL;
              state_q <= ERR;
            end else begin
              gnt_q   <= prel_onehot(prel_q);
              state_q <= PRELOAD;
            end
          end else if (boot_q == BOOT_SD) begin
            err_q   <= ERR_BOOT;
            state_q <= ERR;
          end else begin
            boot_start_q <= 1'b1;
            state_q      <= AUTO;
          end
        end
        PRELOAD: begin
          if (gnt_hit) begin
            gnt_q   <= '0;
            state_q <= RUN;
          end else if (tout) begin
            gnt_q   <= '0;
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        AUTO: begin
          if (tout) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // A valid EOC takes priority over a coincident timeout
          if (eoc_vld) begin
            exit_q  <= {1'b0, eoc_wdata_i[31:1]};
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (tout) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        ERR: begin
          done_q  <= 1'b1;
          state_q <= FIN;
        end
        FIN: begin
          state_q <= FIN;
        end
        default: begin
          state_q <= PWRUP;
        end
      endcase
    end
  end

  assign preload_gnt_o = gnt_q;
  assign boot_start_o  = boot_start_q;
  assign done_o        = done_q;
  assign exit_code_o   = exit_q;
  assign error_o       = err_q;

endmodule

// File: tb/tb_iguana_boot_seq.sv
// Testbench for iguana_boot_seq with a short power-up and timeout.
module tb_iguana_boot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  boot_mode;
  logic [1:0]  preload_mode;
  logic        hyp_pwr_done;
  logic [3:0]  progress;
  logic [2:0]  preload_gnt;
  logic [2:0]  preload_done;
  logic        boot_start;
  logic        eoc_we;
  logic [31:0] eoc_wdata;
  logic        done;
  logic [31:0] exit_code;
  logic [1:0]  error;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  iguana_boot_seq #(
    .PowerupCycles (10),
    .NumItvs       (5),
    .TimeoutCycles (50)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .boot_mode_i    (boot_mode),
    .preload_mode_i (preload_mode),
    .hyp_pwr_done_o (hyp_pwr_done),
    .progress_o     (progress),
    .preload_gnt_o  (preload_gnt),
    .preload_done_i (preload_done),
    .boot_start_o   (boot_start),
    .eoc_we_i       (eoc_we),
    .eoc_wdata_i    (eoc_wdata),
    .done_o         (done),
    .exit_code_o    (exit_code),
    .error_o        (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    chk(tag, obs, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    push(0); push(0); push(0); push(0); push(0); push(0); push(0);
    pop_chk({tag, "_hyp"},  32'(hyp_pwr_done));
    pop_chk({tag, "_prog"}, 32'(progress));
    pop_chk({tag, "_gnt"},  32'(preload_gnt));
    pop_chk({tag, "_bst"},  32'(boot_start));
    pop_chk({tag, "_done"}, 32'(done));
    pop_chk({tag, "_exit"}, exit_code);
    pop_chk({tag, "_err"},  32'(error));
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    eoc_we       = 1'b0;
    eoc_wdata    = '0;
    preload_done = '0;
    tick;
    tick;
    all_zero("rst");
    rst = 1'b0;
  endtask

  task automatic pwrup(input logic [1:0] b, input logic [1:0] p);
    boot_mode    = b;
    preload_mode = p;
    do_reset;
    repeat (10) tick;
  endtask

  task automatic eoc_write(input logic [31:0] d);
    eoc_we    = 1'b1;
    eoc_wdata = d;
    tick;
    eoc_we    = 1'b0;
    eoc_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    boot_mode    = 2'd0;
    preload_mode = 2'd1;
    eoc_we       = 1'b0;
    eoc_wdata    = '0;
    preload_done = '0;

    // Power-up progress and preload via serial link
    do_reset;
    for (int n = 1; n <= 10; n++) begin
      push(32'(n / 2));
      push(32'(n == 10));
      tick;
      pop_chk("prog", 32'(progress));
      pop_chk("hyp",  32'(hyp_pwr_done));
    end
    tick;
    push(32'b010);
    pop_chk("gnt_slink", 32'(preload_gnt));
    // EOC during PRELOAD and non-granted done bits are ignored
    eoc_we       = 1'b1;
    eoc_wdata    = 32'h5;
    preload_done = 3'b101;
    tick;
    eoc_we       = 1'b0;
    preload_done = 3'b000;
    push(0); push(0); push(32'b010);
    pop_chk("prel_eoc_done", 32'(done));
    pop_chk("prel_eoc_exit", exit_code);
    pop_chk("gnt_hold", 32'(preload_gnt));
    preload_done = 3'b111;
    tick;
    preload_done = 3'b000;
    push(0);
    pop_chk("gnt_drop", 32'(preload_gnt));
    eoc_write(32'h0000_0007);
    push(3); push(1); push(0);
    pop_chk("slink_exit", exit_code);
    pop_chk("slink_done", 32'(done));
    pop_chk("slink_err",  32'(error));
    eoc_write(32'h0000_0009);
    push(3);
    pop_chk("fin_exit_hold", exit_code);

    // Autonomous boot
    pwrup(2'd2, 2'd0);
    tick;
    push(1);
    pop_chk("bst_pulse", 32'(boot_start));
    tick;
    push(0);
    pop_chk("bst_low", 32'(boot_start));
    eoc_write(32'h0000_0002);
    push(0);
    pop_chk("auto_inval_done", 32'(done));
    eoc_write(32'h0000_0001);
    push(1); push(0); push(0);
    pop_chk("auto_done", 32'(done));
    pop_chk("auto_exit", exit_code);
    pop_chk("auto_err",  32'(error));

    // Unsupported boot mode
    pwrup(2'd1, 2'd0);
    tick;
    push(1); push(0); push(0);
    pop_chk("sd_err", 32'(error));
    pop_chk("sd_gnt", 32'(preload_gnt));
    pop_chk("sd_bst", 32'(boot_start));
    tick;
    push(1); push(1);
    pop_chk("sd_done",     32'(done));
    pop_chk("sd_err_hold", 32'(error));

    // Reserved preload mode
    pwrup(2'd0, 2'd3);
    tick;
    tick;
    push(2); push(1); push(0);
    pop_chk("rsvd_err",  32'(error));
    pop_chk("rsvd_done", 32'(done));
    pop_chk("rsvd_gnt",  32'(preload_gnt));

    // Timeout exactly 50 cycles after DECIDE
    pwrup(2'd3, 2'd0);
    repeat (49) tick;
    push(0); push(0);
    pop_chk("to_pre_err",  32'(error));
    pop_chk("to_pre_done", 32'(done));
    tick;
    push(3); push(1);
    pop_chk("to_err",  32'(error));
    pop_chk("to_done", 32'(done));

    // Valid EOC coincident with timeout wins
    pwrup(2'd3, 2'd0);
    repeat (49) tick;
    eoc_write(32'h0000_000B);
    push(0); push(1); push(5);
    pop_chk("race_err",  32'(error));
    pop_chk("race_done", 32'(done));
    pop_chk("race_exit", exit_code);

    // Reset in the middle of PRELOAD restarts the power-up wait
    pwrup(2'd0, 2'd2);
    tick;
    push(32'b100);
    pop_chk("gnt_uart", 32'(preload_gnt));
    rst = 1'b1;
    tick;
    all_zero("midrst");
    rst = 1'b0;
    tick;
    push(0);
    pop_chk("restart_prog0", 32'(progress));
    tick;
    push(1); push(0);
    pop_chk("restart_prog1", 32'(progress));
    pop_chk("restart_hyp",   32'(hyp_pwr_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
